// File: rtl/tl_wdata_feeder_pkg.sv
// Shared SATA host constants: FIFO sizing default and feeder FSM encoding.
package tl_wdata_feeder_pkg;

    localparam int FEEDER_ADDR_W = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/tl_wdata_feeder_ram.sv
// Simple dual-port RAM: one synchronous write port and one registered read
// port on the same clock. A read of the address being written that edge
// returns the old contents.
module tl_wdata_feeder_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read port
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/tl_wdata_feeder.sv
// Write-data feeder: buffers host dwords in a RAM FIFO with a show-ahead
// output register and hands them to the transport layer for a transfer of
// a programmed length.
module tl_wdata_feeder
    import tl_wdata_feeder_pkg::*;
#(
    parameter int ADDR_W = FEEDER_ADDR_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     al_data_in,
    input  logic            al_data_val_in,
    input  logic            al_start_in,
    input  logic [ADDR_W:0] al_len_in,
    input  logic            al_clr_in,
    output logic [31:0]     tl_data_out,
    output logic            tl_data_val_out,
    output logic            tl_data_last_out,
    input  logic            tl_data_strobe_in,
    input  logic            tl_abort_in,
    output logic [ADDR_W:0] level_out,
    output logic            busy_out,
    output logic            done_out,
    output logic            err_out,
    output logic            ovf_out
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

    feeder_state_t     state, state_nxt;
    logic [ADDR_W-1:0] wptr, rptr, rd_addr;
    logic [ADDR_W:0]   level, remaining, ram_cnt, ram_left;
    logic [31:0]       out_data, ram_q;
    logic              out_vld, q_vld;
    logic              abort, wr, consume, pop, start_err, ovf_set;

    tl_wdata_feeder_ram #(.ADDR_W(ADDR_W), .DATA_W(32)) u_ram (
        .clk     (clk),
        .wr_en   (wr),
        .wr_addr (wptr),
        .wr_data (al_data_in),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // Per-cycle strobes; abort overrides any consume or write in its cycle.
    // ram_q always holds mem[rptr] once q_vld is set, so the read address
    // runs one ahead whenever the head entry moves into the output register.
    always_comb begin
        abort     = (state == ST_SEND) && tl_abort_in;
        wr        = al_data_val_in && (level != DEPTH) && !abort;
        consume   = (state == ST_SEND) && out_vld && tl_data_strobe_in && !abort;
        ram_cnt   = level - {{ADDR_W{1'b0}}, out_vld};
        pop       = q_vld && (!out_vld || consume);
        ram_left  = ram_cnt - {{ADDR_W{1'b0}}, pop};
        rd_addr   = pop ? rptr + ADDR_W'(1) : rptr;
        start_err = al_start_in && ((state == ST_SEND) || (al_len_in == '0));
        ovf_set   = al_data_val_in && (level == DEPTH);
    end

    // FIFO pointers, read-data valid, output register and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            q_vld    <= 1'b0;
            out_vld  <= 1'b0;
            out_data <= '0;
            level    <= '0;
        end else if (abort) begin
            wptr    <= '0;
            rptr    <= '0;
            q_vld   <= 1'b0;
            out_vld <= 1'b0;
            level   <= '0;
        end else begin
            if (wr)  wptr <= wptr + ADDR_W'(1);
            if (pop) rptr <= rptr + ADDR_W'(1);
            // Entries written this edge are not readable until the next one
            q_vld <= (ram_left != '0);
            if (pop) begin
                out_vld  <= 1'b1;
                out_data <= ram_q;
            end else if (consume) begin
                out_vld <= 1'b0;
            end
            level <= level + {{ADDR_W{1'b0}}, wr} - {{ADDR_W{1'b0}}, consume};
        end
    end

    // FSM next state and transfer-facing outputs
    always_comb begin
        state_nxt        = state;
        tl_data_val_out  = 1'b0;
        tl_data_last_out = 1'b0;
        case (state)
            ST_IDLE: begin
                if (al_start_in && (al_len_in != '0)) state_nxt = ST_SEND;
            end
            ST_SEND: begin
                tl_data_val_out  = out_vld;
                tl_data_last_out = out_vld && (remaining == ONE);
                if (abort) state_nxt = ST_IDLE;
                else if (consume && (remaining == ONE)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, remaining count, completion pulse and sticky flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            done_out  <= 1'b0;
            err_out   <= 1'b0;
            ovf_out   <= 1'b0;
        end else begin
            state    <= state_nxt;
            done_out <= consume && (remaining == ONE);
            if (abort) remaining <= '0;
            else if (consume) remaining <= remaining - ONE;
            else if ((state == ST_IDLE) && al_start_in && (al_len_in != '0)) remaining <= al_len_in;
            if (start_err) err_out <= 1'b1;
            else if (al_clr_in) err_out <= 1'b0;
            if (ovf_set) ovf_out <= 1'b1;
            else if (al_clr_in) ovf_out <= 1'b0;
        end
    end

    assign tl_data_out = out_data;
    assign level_out   = level;
    assign busy_out    = (state == ST_SEND);

endmodule
